// File: rtl/dffram_arb_pkg.sv
// Shared types for the RAM256 arbiter.
// Owner encoding, default widths, request bundle.
package dffram_arb_pkg;

  localparam int DEF_AW    = 8;
  localparam int DEF_WSIZE = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_FILL = 2'd2
  } owner_e;

  typedef struct packed {
    logic [DEF_WSIZE-1:0]   we;
    logic [DEF_AW-1:0]      addr;
    logic [DEF_WSIZE*8-1:0] wdata;
  } req_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear priority.
// Used for host starvation and fill burst length.
module arb_sat_counter #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear wins, increment stops at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != W'(MAX))
      cnt_d = cnt_q + W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/dffram_arbiter.sv
// Host / line-fill arbiter for the RAM256 DFFRAM.
// Fill-first priority, bounded by starvation and burst limits.
module dffram_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int WSIZE      = DEF_WSIZE,
  parameter int AW         = DEF_AW,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               h_req,
  input  logic [WSIZE-1:0]   h_we,
  input  logic [AW-1:0]      h_addr,
  input  logic [WSIZE*8-1:0] h_wdata,
  output logic               h_gnt,
  output logic               h_rvalid,
  output logic [WSIZE*8-1:0] h_rdata,
  input  logic               f_req,
  input  logic [WSIZE-1:0]   f_we,
  input  logic [AW-1:0]      f_addr,
  input  logic [WSIZE*8-1:0] f_wdata,
  input  logic               f_lock,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [WSIZE*8-1:0] f_rdata,
  output logic               ram_en,
  output logic [WSIZE-1:0]   ram_we,
  output logic [AW-1:0]      ram_a,
  output logic [WSIZE*8-1:0] ram_di,
  input  logic [WSIZE*8-1:0] ram_do
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          starve_at;
  logic          burst_at;
  logic          host_pri;
  logic          cnt_unused;
  owner_e        owner_q;
  owner_e        owner_d;

  // While the fill holds its lock, only the burst limit yields
  assign host_pri = (starve_at & ~f_lock) | burst_at;

  assign h_gnt = rst_n & h_req & (~f_req | host_pri);
  assign f_gnt = rst_n & f_req & ~(h_req & host_pri);

  assign cnt_unused = ^{starve_cnt, burst_cnt};

  arb_sat_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (h_req & ~h_gnt),
    .clr_i    (h_gnt | ~h_req),
    .cnt_o    (starve_cnt),
    .at_max_o (starve_at)
  );

  arb_sat_counter #(.MAX(BURST_MAX)) u_burst (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (f_gnt & f_lock),
    .clr_i    (~f_lock | h_gnt),
    .cnt_o    (burst_cnt),
    .at_max_o (burst_at)
  );

  // RAM pins follow the granted requester, idle at zero
  always_comb begin
    ram_en = 1'b0;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    unique case (1'b1)
      h_gnt: begin
        ram_en = 1'b1;
        ram_we = h_we;
        ram_a  = h_addr;
        ram_di = h_wdata;
      end
      f_gnt: begin
        ram_en = 1'b1;
        ram_we = f_we;
        ram_a  = f_addr;
        ram_di = f_wdata;
      end
      default: ;
    endcase
  end

  // who gets Do0 next cycle
  always_comb begin
    owner_d = OWN_NONE;
    if (h_gnt && h_we == '0)
      owner_d = OWN_HOST;
    else if (f_gnt && f_we == '0)
      owner_d = OWN_FILL;
  end

  // response-owner register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  assign h_rvalid = (owner_q == OWN_HOST);
  assign f_rvalid = (owner_q == OWN_FILL);
  assign h_rdata  = h_rvalid ? ram_do : '0;
  assign f_rdata  = f_rvalid ? ram_do : '0;

endmodule
